// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: computes the 64-bit result up front,
// holds it through a fixed busy window, then commits it to architectural HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data,
  output logic        stall_md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pendHi_q, pendHi_d, pendLo_q, pendLo_d;

  logic [63:0] prodS, prodU;
  logic [31:0] aMag, bMag, quoMag, remMag, quoS, remS, quoU, remU;
  logic        isMulDiv;

  assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prodU = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign aMag   = A[31] ? (32'd0 - A) : A;
  assign bMag   = B[31] ? (32'd0 - B) : B;
  assign quoMag = aMag / bMag;
  assign remMag = aMag % bMag;
  assign quoS   = (A[31] ^ B[31]) ? (32'd0 - quoMag) : quoMag;
  assign remS   = A[31] ? (32'd0 - remMag) : remMag;
  assign quoU   = A / B;
  assign remU   = A % B;

  assign isMulDiv = start && (mdu_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign busy     = (cnt_q != '0);
  assign stall_md = md_D && (busy || isMulDiv);
  assign HI       = hi_q;
  assign LO       = lo_q;

  always_comb begin
    case (mdu_op)
      OP_MFHI: rd_data = hi_q;
      OP_MFLO: rd_data = lo_q;
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pendHi_q <= 32'd0;
      pendLo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
    end
  end

  // Requests are only honoured in IDLE; a divide by zero re-commits the current HI/LO.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              {pendHi_d, pendLo_d} = prodS;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              {pendHi_d, pendLo_d} = prodU;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV: begin
              if (B == 32'd0) {pendHi_d, pendLo_d} = {hi_q, lo_q};
              else            {pendHi_d, pendLo_d} = {remS, quoS};
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              if (B == 32'd0) {pendHi_d, pendLo_d} = {hi_q, lo_q};
              else            {pendHi_d, pendLo_d} = {remU, quoU};
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = pendHi_q;
          lo_d    = pendLo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected commits and probes,
// a negedge monitor pops and compares them against the DUT.
module tb_mdu_ctrl;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6;
  localparam logic [3:0] OP_MFHI = 4'd7, OP_MFLO = 4'd8;
  localparam int SEL_BUSY = 0, SEL_HI = 1, SEL_LO = 2, SEL_RD = 3, SEL_STALL = 4;

  logic        clk, reset, start, md_D;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy, stall_md;
  logic [31:0] HI, LO, rd_data;

  typedef struct {string name; logic [31:0] hi; logic [31:0] lo; int cycles;} commit_t;
  typedef struct {string name; int sel; logic [31:0] exp;} probe_t;

  commit_t commitQ[$];
  probe_t  probeQ[$];
  int vectors = 0;
  int miscompares = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .md_D(md_D), .busy(busy), .HI(HI), .LO(LO), .rd_data(rd_data), .stall_md(stall_md)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset as seen at the most recent edge, so a reset-induced busy drop is not a commit.
  logic rstSeen = 1'b0;
  always @(posedge clk) rstSeen = reset;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic md);
    start  = st;
    mdu_op = op;
    A      = a;
    B      = b;
    md_D   = md;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    probe_t p;
    p.name = name;
    p.sel  = sel;
    p.exp  = exp;
    probeQ.push_back(p);
  endtask

  task automatic expectCommit(input string name, input logic [31:0] hi, input logic [31:0] lo,
                              input int cycles);
    commit_t c;
    c.name = name;
    c.hi = hi;
    c.lo = lo;
    c.cycles = cycles;
    commitQ.push_back(c);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, op, a, b, md_D);
    step();
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, md_D);
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 100 && busy === 1'b1; i++) step();
    if (busy === 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: busy still %b, required 0", name, busy);
    end
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: drains probes every cycle and scores each busy window when busy falls.
  logic        wasBusy = 1'b0;
  logic        holdBad = 1'b0;
  int          busyCnt = 0;
  logic [31:0] lastHi = 32'd0, lastLo = 32'd0, act;
  probe_t      pm;
  commit_t     cm;

  always @(negedge clk) begin
    while (probeQ.size() > 0) begin
      pm = probeQ.pop_front();
      case (pm.sel)
        SEL_BUSY:  act = {31'd0, busy};
        SEL_HI:    act = HI;
        SEL_LO:    act = LO;
        SEL_RD:    act = rd_data;
        default:   act = {31'd0, stall_md};
      endcase
      compare(pm.name, act, pm.exp);
    end
    if (busy === 1'b1) begin
      if (!wasBusy) begin
        busyCnt = 0;
        holdBad = 1'b0;
      end
      busyCnt++;
      if (HI !== lastHi || LO !== lastLo) holdBad = 1'b1;
      if (busyCnt == 200) compare("busy window bound", {31'd0, busy}, 32'd0);
    end else begin
      if (wasBusy && !rstSeen) begin
        if (commitQ.size() == 0) begin
          compare("unexpected commit", 32'd1, 32'd0);
        end else begin
          cm = commitQ.pop_front();
          compare({cm.name, " busy cycles"}, busyCnt, cm.cycles);
          compare({cm.name, " HI/LO held"}, {31'd0, holdBad}, 32'd0);
          compare({cm.name, " HI"}, HI, cm.hi);
          compare({cm.name, " LO"}, LO, cm.lo);
        end
      end
      lastHi = HI;
      lastLo = LO;
    end
    wasBusy = (busy === 1'b1);
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
    checkOutput("reset busy", SEL_BUSY, 32'd0);
    checkOutput("reset HI", SEL_HI, 32'd0);
    checkOutput("reset LO", SEL_LO, 32'd0);
    checkOutput("reset rd_data", SEL_RD, 32'd0);
    checkOutput("reset stall_md", SEL_STALL, 32'd0);
    step();

    expectCommit("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    waitIdle("mult");

    expectCommit("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitIdle("multu");

    expectCommit("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    mdu_op = OP_MFHI;
    checkOutput("mfhi during run", SEL_RD, 32'h0000_0001);
    waitIdle("div");
    mdu_op = OP_NONE;

    issue(OP_MTHI, 32'h1234, 32'd0);
    checkOutput("mthi HI", SEL_HI, 32'h1234);
    issue(OP_MTLO, 32'h5678, 32'd0);
    checkOutput("mtlo LO", SEL_LO, 32'h5678);
    expectCommit("divu by zero", 32'h1234, 32'h5678, 10);
    issue(OP_DIVU, 32'd100, 32'd0);
    waitIdle("divu");
    applyStimulus(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
    checkOutput("mfhi rd_data", SEL_RD, 32'h1234);
    step();
    applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
    checkOutput("mflo rd_data", SEL_RD, 32'h5678);
    step();

    expectCommit("div 20/3 stalled", 32'd2, 32'd6, 10);
    applyStimulus(1'b1, OP_DIV, 32'd20, 32'd3, 1'b1);
    checkOutput("stall start cycle", SEL_STALL, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 3) applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9, 1'b1);
      else        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
      checkOutput($sformatf("stall busy cycle %0d", i + 1), SEL_STALL, 32'd1);
    end
    step();
    checkOutput("stall after commit", SEL_STALL, 32'd0);
    checkOutput("busy after commit", SEL_BUSY, 32'd0);
    md_D = 1'b0;
    step();

    issue(OP_MULT, 32'd3, 32'd4);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort busy", SEL_BUSY, 32'd0);
    checkOutput("abort HI", SEL_HI, 32'd0);
    checkOutput("abort LO", SEL_LO, 32'd0);
    repeat (8) step();
    checkOutput("no late commit HI", SEL_HI, 32'd0);
    checkOutput("no late commit LO", SEL_LO, 32'd0);
    checkOutput("no late commit busy", SEL_BUSY, 32'd0);

    expectCommit("div overflow", 32'd0, 32'h8000_0000, 10);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (9) step();
    expectCommit("mult back-to-back", 32'd0, 32'd42, 5);
    applyStimulus(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
    step();
    checkOutput("idle at t+N", SEL_BUSY, 32'd0);
    step();
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("restart accepted", SEL_BUSY, 32'd1);
    waitIdle("mult back-to-back");

    repeat (3) step();
    compare("pending commits left", commitQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
